// File: rtl/pc_fetch.sv
// Instruction fetch stage: walks the PC through instruction memory, feeds IF/ID,
// and defers branch redirects so the in-flight fetch still completes (delay slot).
module pc_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        redir_pending;
  logic [31:0] redir_target;
  logic [31:0] buf_pc;
  logic [31:0] buf_inst;

  logic        pc_load;
  logic        capture;
  logic        to_buf;
  logic        from_buf;
  logic        bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_req_o = 1'b0;
    pc_load   = 1'b0;
    capture   = 1'b0;
    to_buf    = 1'b0;
    from_buf  = 1'b0;
    bubble    = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          pc_load = 1'b1;
          if (stall) begin
            to_buf    = 1'b1;
            state_nxt = HOLD;
          end else begin
            capture = 1'b1;
          end
        end else if (!stall) begin
          bubble = 1'b1;
        end
      end
      HOLD: begin
        if (!stall) begin
          from_buf  = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // A redirect arriving in the same cycle as the PC update wins over an older pending one.
  always_comb begin
    if (branch_flag_i) begin
      next_pc = branch_target_i;
    end else if (redir_pending) begin
      next_pc = redir_target;
    end else begin
      next_pc = pc + 32'd4;
    end
  end

  assign mem_addr_o = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      redir_pending <= 1'b0;
      redir_target  <= 32'h0;
      buf_pc        <= 32'h0;
      buf_inst      <= 32'h0;
      if_pc         <= 32'h0;
      if_inst       <= BUBBLE_INST;
      if_valid      <= 1'b0;
    end else begin
      if (pc_load) begin
        pc <= next_pc;
      end

      if (branch_flag_i) begin
        redir_target <= branch_target_i;
      end
      if (pc_load) begin
        redir_pending <= 1'b0;
      end else if (branch_flag_i) begin
        redir_pending <= 1'b1;
      end

      if (to_buf) begin
        buf_pc   <= pc;
        buf_inst <= mem_rdata_i;
      end

      if (capture) begin
        if_pc    <= pc;
        if_inst  <= mem_rdata_i;
        if_valid <= 1'b1;
      end else if (from_buf) begin
        if_pc    <= buf_pc;
        if_inst  <= buf_inst;
        if_valid <= 1'b1;
      end else if (bubble) begin
        if_inst  <= BUBBLE_INST;
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Testbench for pc_fetch: a simple memory model answers requests, and two scoreboards
// track the expected request addresses and the expected IF/ID deliveries in order.
module tb_pc_fetch;

  localparam logic [31:0] BUBBLE = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] reqQ[$];
  logic [31:0] delQ[$];
  bit          monitorOn = 1'b0;
  logic        prevValid = 1'b0;
  logic [31:0] prevPc = 32'h0;
  logic [31:0] monExp;

  pc_fetch #(
    .RESET_PC   (32'h0000_0000),
    .BUBBLE_INST(BUBBLE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch_flag_i  (branch_flag_i),
    .branch_target_i(branch_target_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_ack_i      (mem_ack_i),
    .mem_rdata_i    (mem_rdata_i),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_valid       (if_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instWord(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign mem_rdata_i = instWord(mem_addr_o);

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Inputs change just after the falling edge so the rising edge sees them settled.
  task automatic applyStimulus(input logic r, input logic s, input logic a,
                               input logic b, input logic [31:0] t);
    @(negedge clk);
    #1;
    rst             = r;
    stall           = s;
    mem_ack_i       = a;
    branch_flag_i   = b;
    branch_target_i = t;
  endtask

  // Sampled after the drivers settle: sees exactly what the next rising edge will see.
  always begin
    @(negedge clk);
    #2;
    if (monitorOn) begin
      if (!rst && mem_req_o && mem_ack_i) begin
        if (reqQ.size() == 0) begin
          checkOutput("req_extra", 32'(reqQ.size()), 32'd1);
        end else begin
          monExp = reqQ.pop_front();
          checkOutput("req_addr", mem_addr_o, monExp);
        end
      end
      if (if_valid === 1'b1 && (prevValid !== 1'b1 || if_pc !== prevPc)) begin
        if (delQ.size() == 0) begin
          checkOutput("deliver_extra", 32'(delQ.size()), 32'd1);
        end else begin
          monExp = delQ.pop_front();
          checkOutput("deliver_pc", if_pc, monExp);
          checkOutput("deliver_inst", if_inst, instWord(monExp));
        end
      end
      prevValid = if_valid;
      prevPc    = if_pc;
    end
  end

  initial begin
    rst             = 1'b1;
    stall           = 1'b0;
    mem_ack_i       = 1'b0;
    branch_flag_i   = 1'b0;
    branch_target_i = 32'h0;

    foreach (reqQ[i]) reqQ.delete(i);
    reqQ = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h100, 32'h300,
             32'h304, 32'h308, 32'hFFFF_FFFC, 32'h0, 32'h403, 32'h0};
    delQ = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h100, 32'h300,
             32'h304, 32'h308, 32'hFFFF_FFFC, 32'h0, 32'h403, 32'h0};

    applyStimulus(1, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 1, 0, 32'h0);
    monitorOn = 1'b1;

    // First cycle out of reset: IDLE, reset outputs visible.
    applyStimulus(0, 0, 1, 0, 32'h0);
    checkOutput("rst_if_pc", if_pc, 32'h0);
    checkOutput("rst_if_inst", if_inst, BUBBLE);
    checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
    checkOutput("idle_no_req", 32'(mem_req_o), 32'd0);

    applyStimulus(0, 0, 1, 0, 32'h0);
    checkOutput("first_req", 32'(mem_req_o), 32'd1);
    applyStimulus(0, 0, 1, 0, 32'h0);

    // Two wait states on address 0x8.
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkOutput("wait_addr0", mem_addr_o, 32'h8);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkOutput("wait_addr1", mem_addr_o, 32'h8);
    checkOutput("wait_valid1", 32'(if_valid), 32'd0);
    checkOutput("wait_bubble1", if_inst, BUBBLE);
    applyStimulus(0, 0, 1, 0, 32'h0);
    checkOutput("wait_addr2", mem_addr_o, 32'h8);
    checkOutput("wait_valid2", 32'(if_valid), 32'd0);
    checkOutput("wait_bubble2", if_inst, BUBBLE);

    // Stall on the ack of 0xC: word parks in the buffer, outputs hold 0x8.
    applyStimulus(0, 1, 1, 0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 0, 0, 32'h0);
      checkOutput("hold_no_req", 32'(mem_req_o), 32'd0);
      checkOutput("hold_if_pc", if_pc, 32'h8);
      checkOutput("hold_if_inst", if_inst, instWord(32'h8));
      checkOutput("hold_if_valid", 32'(if_valid), 32'd1);
    end
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkOutput("hold_release_no_req", 32'(mem_req_o), 32'd0);
    applyStimulus(0, 0, 1, 0, 32'h0);
    checkOutput("after_hold_addr", mem_addr_o, 32'h10);
    checkOutput("after_hold_if_pc", if_pc, 32'hC);

    // Branch to 0x100 while 0x14 is the fetch in flight.
    applyStimulus(0, 0, 1, 1, 32'h100);
    checkOutput("slot_addr", mem_addr_o, 32'h14);

    // Two redirects during a three-cycle wait on 0x100; the later one wins.
    applyStimulus(0, 0, 0, 1, 32'h200);
    checkOutput("branch_addr", mem_addr_o, 32'h100);
    applyStimulus(0, 0, 0, 1, 32'h300);
    applyStimulus(0, 0, 1, 0, 32'h0);
    checkOutput("latest_wait_addr", mem_addr_o, 32'h100);
    applyStimulus(0, 0, 1, 0, 32'h0);
    checkOutput("latest_wins_addr", mem_addr_o, 32'h300);
    applyStimulus(0, 0, 1, 0, 32'h0);

    // Wrap from 0xFFFF_FFFC to zero, then an unaligned target.
    applyStimulus(0, 0, 1, 1, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 1, 0, 32'h0);
    applyStimulus(0, 0, 1, 1, 32'h403);
    checkOutput("wrap_addr", mem_addr_o, 32'h0);
    applyStimulus(0, 0, 1, 0, 32'h0);
    checkOutput("unaligned_addr", mem_addr_o, 32'h403);

    // Reset while waiting on 0x407, with the late ack landing in the reset cycle.
    applyStimulus(0, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 1, 0, 32'h0);
    applyStimulus(0, 0, 1, 0, 32'h0);
    checkOutput("midrst_if_pc", if_pc, 32'h0);
    checkOutput("midrst_if_inst", if_inst, BUBBLE);
    checkOutput("midrst_if_valid", 32'(if_valid), 32'd0);
    checkOutput("midrst_no_req", 32'(mem_req_o), 32'd0);
    applyStimulus(0, 0, 1, 0, 32'h0);
    checkOutput("midrst_refetch_addr", mem_addr_o, 32'h0);
    checkOutput("midrst_still_invalid", 32'(if_valid), 32'd0);

    applyStimulus(0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    monitorOn = 1'b0;

    checkOutput("reqQ_drained", 32'(reqQ.size()), 32'd0);
    checkOutput("delQ_drained", 32'(delQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
